// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned TAG_W   = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned BLOCK_W = 32;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StAllocate  = 2'd2,
        StUpdate    = 2'd3
    } state_e;

    function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFF_W-1:0]   off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Data/tag/valid/dirty storage for the cache; combinational read of the indexed line.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [BLOCK_W-1:0] rd_data_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    input  logic               wr_en_i,
    input  logic [OFF_W-1:0]   wr_off_i,
    input  logic [7:0]         wr_byte_i,
    input  logic               fill_en_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic [BLOCK_W-1:0] fill_data_i
);

    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_d [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;

    // Reset clears only the status bits; data and tags keep stale contents.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (RESET) begin
            valid_d = '0;
            dirty_d = '0;
        end else if (fill_en_i) begin
            data_d[idx_i]  = fill_data_i;
            tag_d[idx_i]   = fill_tag_i;
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (wr_en_i) begin
            data_d[idx_i][{wr_off_i, 3'b000} +: 8] = wr_byte_i;
            dirty_d[idx_i] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        data_q  <= data_d;
        tag_q   <= tag_d;
        valid_q <= valid_d;
        dirty_q <= dirty_d;
    end

    assign rd_data_o  = data_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: hit logic, miss FSM, output muxing.
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned MEM_ADDR_W = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [7:0]            ADDRESS,
    input  logic [7:0]            WRITEDATA,
    output logic [7:0]            READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [BLOCK_W-1:0] line_data;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid, line_dirty, hit;
    logic               wr_en, fill_en;

    state_e             state_q, state_d;
    logic               wait_q, wait_d;
    logic [BLOCK_W-1:0] rdata_q, rdata_d;

    assign tag = ADDRESS[7:5];
    assign idx = ADDRESS[4:2];
    assign off = ADDRESS[1:0];
    assign hit = line_valid && (line_tag == tag);

    dcache_line_array #(
        .NUM_BLOCKS(NUM_BLOCKS)
    ) u_lines (
        .CLK        (CLK),
        .RESET      (RESET),
        .idx_i      (idx),
        .rd_data_o  (line_data),
        .rd_tag_o   (line_tag),
        .rd_valid_o (line_valid),
        .rd_dirty_o (line_dirty),
        .wr_en_i    (wr_en),
        .wr_off_i   (off),
        .wr_byte_i  (WRITEDATA),
        .fill_en_i  (fill_en),
        .fill_tag_i (tag),
        .fill_data_i(rdata_q)
    );

    // wait_q marks that at least one cycle has been spent in a memory state, so a
    // memory that raises its busy flag a cycle late is not mistaken for completion.
    always_comb begin
        state_d       = state_q;
        wait_d        = 1'b0;
        rdata_d       = rdata_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = ADDRESS[7:2];
        MEM_WRITEDATA = line_data;
        wr_en         = 1'b0;
        fill_en       = 1'b0;
        READDATA      = RESET ? 8'h00 : sel_byte(line_data, off);
        if (RESET) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((READ || WRITE) && !hit) begin
                        BUSYWAIT = 1'b1;
                        state_d  = (line_valid && line_dirty) ? StWriteback : StAllocate;
                    end else if (WRITE && hit) begin
                        wr_en = 1'b1;
                    end
                end
                StWriteback: begin
                    BUSYWAIT    = 1'b1;
                    MEM_WRITE   = 1'b1;
                    MEM_ADDRESS = {line_tag, idx};
                    if (wait_q && !MEM_BUSYWAIT) state_d = StAllocate;
                    else wait_d = 1'b1;
                end
                StAllocate: begin
                    BUSYWAIT = 1'b1;
                    MEM_READ = 1'b1;
                    if (wait_q && !MEM_BUSYWAIT) begin
                        state_d = StUpdate;
                        rdata_d = MEM_READDATA;
                    end else begin
                        wait_d = 1'b1;
                    end
                end
                StUpdate: begin
                    BUSYWAIT = 1'b1;
                    fill_en  = 1'b1;
                    state_d  = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
        wait_q  <= wait_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a fixed-latency block memory model.
module tb_dcache;

    logic        CLK, RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    int errors = 0;
    int checks = 0;
    int n_wb, n_al, n_up, n_bad;

    // Memory model: busy for mem_lat cycles from the cycle it sees a request.
    logic [31:0] mem [64];
    logic        mem_load;
    int          mem_lat;
    int          mcnt;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mcnt < mem_lat);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (mem_load) begin
            for (int b = 0; b < 64; b++) begin
                mem[b] <= {b[5:0], 2'd3, b[5:0], 2'd2, b[5:0], 2'd1, b[5:0], 2'd0};
            end
            mcnt <= 0;
        end else if (MEM_READ || MEM_WRITE) begin
            if (mcnt < mem_lat) begin
                mcnt <= mcnt + 1;
            end else begin
                mcnt <= 0;
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end
        end else begin
            mcnt <= 0;
        end
    end

    dcache u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walks a miss from the IDLE detect cycle until BUSYWAIT drops, classifying stall
    // cycles; n_up counts stall cycles with no memory request (detect + UPDATE).
    task automatic run_miss(input logic [5:0] wb_addr, input logic [31:0] wb_data,
                            input logic [5:0] al_addr, output int wb, output int al,
                            output int up, output int bad);
        wb = 0; al = 0; up = 0; bad = 0;
        for (int i = 0; i < 100 && BUSYWAIT; i++) begin
            if (MEM_WRITE) begin
                wb++;
                if (MEM_ADDRESS !== wb_addr || MEM_WRITEDATA !== wb_data) bad++;
            end else if (MEM_READ) begin
                al++;
                if (MEM_ADDRESS !== al_addr) bad++;
            end else begin
                up++;
            end
            tick();
        end
    endtask

    initial begin
        RESET = 1'b1; mem_load = 1'b1; mem_lat = 5;
        READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        tick(); tick();
        READ = 1'b1; #1;
        check("rst_busywait", 32'(BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(MEM_READ), 32'd0);
        check("rst_readdata", 32'(READDATA), 32'h00);

        // Read miss on 0x00 into an empty cache.
        RESET = 1'b0; mem_load = 1'b0; #1;
        check("miss_busy_now", 32'(BUSYWAIT), 32'd1);
        run_miss(6'h00, 32'h0, 6'h00, n_wb, n_al, n_up, n_bad);
        check("miss_alloc_cycles", 32'(n_al), 32'd6);
        check("miss_wb_cycles", 32'(n_wb), 32'd0);
        check("miss_idle_upd_cycles", 32'(n_up), 32'd2);
        check("miss_addr", 32'(n_bad), 32'd0);
        check("miss_done", 32'(BUSYWAIT), 32'd0);
        check("miss_readdata", 32'(READDATA), 32'h00);

        // Read hit in the same block.
        ADDRESS = 8'h03; #1;
        check("hit_busy", 32'(BUSYWAIT), 32'd0);
        check("hit_no_mem", 32'(MEM_READ), 32'd0);
        check("hit_readdata", 32'(READDATA), 32'h03);
        tick();
        check("hit_busy_next", 32'(BUSYWAIT), 32'd0);

        // Write-allocate 0xAB at 0x05 (index 1 miss).
        READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'hAB; #1;
        check("walloc_busy_now", 32'(BUSYWAIT), 32'd1);
        run_miss(6'h00, 32'h0, 6'h01, n_wb, n_al, n_up, n_bad);
        check("walloc_alloc_cycles", 32'(n_al), 32'd6);
        check("walloc_addr", 32'(n_bad), 32'd0);
        check("walloc_commit_busy", 32'(BUSYWAIT), 32'd0);
        tick();
        WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h05; #1;
        check("walloc_rd_busy", 32'(BUSYWAIT), 32'd0);
        check("walloc_rd_data", 32'(READDATA), 32'hAB);

        // Dirty eviction: 0x25 shares index 1 with a different tag.
        ADDRESS = 8'h25; #1;
        run_miss(6'h01, 32'h0706AB04, 6'h09, n_wb, n_al, n_up, n_bad);
        check("evict_wb_cycles", 32'(n_wb), 32'd6);
        check("evict_alloc_cycles", 32'(n_al), 32'd6);
        check("evict_idle_upd_cycles", 32'(n_up), 32'd2);
        check("evict_addr_data", 32'(n_bad), 32'd0);
        check("evict_readdata", 32'(READDATA), 32'h25);
        check("evict_mem_updated", mem[1], 32'h0706AB04);

        // Offset 3 selects the top byte.
        ADDRESS = 8'h27; #1;
        check("off3_busy", 32'(BUSYWAIT), 32'd0);
        check("off3_readdata", 32'(READDATA), 32'h27);

        // READ and WRITE together behave as a store.
        WRITE = 1'b1; ADDRESS = 8'h26; WRITEDATA = 8'hC3; #1;
        check("rw_busy", 32'(BUSYWAIT), 32'd0);
        tick();
        WRITE = 1'b0; #1;
        check("rw_readdata", 32'(READDATA), 32'hC3);

        // Reset while allocating 0x40.
        tick();
        ADDRESS = 8'h40; #1;
        check("rstmid_busy", 32'(BUSYWAIT), 32'd1);
        tick(); tick(); tick();
        check("rstmid_in_alloc", 32'(MEM_READ), 32'd1);
        RESET = 1'b1; READ = 1'b0; #1;
        check("rstmid_mem_read", 32'(MEM_READ), 32'd0);
        check("rstmid_busywait", 32'(BUSYWAIT), 32'd0);
        tick();
        RESET = 1'b0; #1;
        check("rstmid_idle_mem", 32'(MEM_READ), 32'd0);
        check("rstmid_idle_busy", 32'(BUSYWAIT), 32'd0);
        READ = 1'b1; ADDRESS = 8'h00; #1;
        check("rstmid_remiss", 32'(BUSYWAIT), 32'd1);
        run_miss(6'h00, 32'h0, 6'h00, n_wb, n_al, n_up, n_bad);
        check("rstmid_alloc_cycles", 32'(n_al), 32'd6);
        check("rstmid_readdata", 32'(READDATA), 32'h00);

        // Long memory latency on a refill of 0x08.
        mem_lat = 20;
        ADDRESS = 8'h08; #1;
        run_miss(6'h00, 32'h0, 6'h02, n_wb, n_al, n_up, n_bad);
        check("long_alloc_cycles", 32'(n_al), 32'd21);
        check("long_idle_upd_cycles", 32'(n_up), 32'd2);
        check("long_addr_stable", 32'(n_bad), 32'd0);
        check("long_done", 32'(BUSYWAIT), 32'd0);
        check("long_readdata", 32'(READDATA), 32'h08);

        READ = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
